// File: rtl/tc_io_pad_ctrl.sv
// Pad-ring control: register block driving up to 8 IO pad cells, with
// synchronised, debounced and edge-detected return data feeding an interrupt.
module tc_io_pad_ctrl #(
    parameter int         NumPads     = 8,
    parameter logic [3:0] DefStrength = 4'h4,
    parameter int         CntWidth    = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   reg_req_i,
    input  logic                   reg_we_i,
    input  logic [3:0]             reg_addr_i,
    input  logic [31:0]            reg_wdata_i,
    output logic [31:0]            reg_rdata_o,
    output logic                   reg_ready_o,
    output logic                   reg_err_o,
    output logic [NumPads-1:0]     pad_data_o,
    output logic [NumPads-1:0]     pad_oe_no,
    output logic [4*NumPads-1:0]   pad_strength_o,
    output logic [NumPads-1:0]     pad_pullup_en_o,
    output logic [NumPads-1:0]     pad_pulldown_en_o,
    input  logic [NumPads-1:0]     pad_data_i,
    output logic                   irq_o,
    output logic [NumPads-1:0]     in_o
);

    logic [NumPads-1:0]   out_q, oe_q, oe_n_q, in_q, pullup_q, pulldown_q;
    logic [NumPads-1:0]   rise_en_q, fall_en_q, status_q;
    logic [4*NumPads-1:0] strength_q;
    logic [CntWidth-1:0]  debounce_q;
    logic [CntWidth-1:0]  cnt_q    [NumPads];
    logic [CntWidth-1:0]  cnt_next [NumPads];
    logic [NumPads-1:0]   sync_p0, sync_p1;
    logic [NumPads-1:0]   in_next, rise, fall, status_next, clr, oe_next;
    logic [31:0]          rdata_next, rdata_q;
    logic                 ready_q, err_q, irq_q, wr;
    logic                 unused_wdata;

    assign wr           = reg_req_i & reg_we_i;
    assign unused_wdata = ^reg_wdata_i;

    always_comb begin
        oe_next = oe_q;
        if (wr && reg_addr_i == 4'd1) oe_next = reg_wdata_i[NumPads-1:0];
        clr = '0;
        if (wr && reg_addr_i == 4'd8) clr = reg_wdata_i[NumPads-1:0];
    end

    // Debounce: count while the synced value disagrees with IN, commit on equality with DEBOUNCE.
    always_comb begin
        in_next = in_q;
        rise    = '0;
        fall    = '0;
        for (int k = 0; k < NumPads; k++) begin
            cnt_next[k] = '0;
            if (sync_p1[k] != in_q[k]) begin
                if (cnt_q[k] == debounce_q) begin
                    in_next[k] = sync_p1[k];
                    rise[k]    = sync_p1[k];
                    fall[k]    = ~sync_p1[k];
                end else begin
                    cnt_next[k] = cnt_q[k] + CntWidth'(1);
                end
            end
        end
        status_next = (status_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);
    end

    always_comb begin
        rdata_next = '0;
        if (reg_req_i && !reg_we_i) begin
            case (reg_addr_i)
                4'd0: rdata_next[NumPads-1:0]   = out_q;
                4'd1: rdata_next[NumPads-1:0]   = oe_q;
                4'd2: rdata_next[NumPads-1:0]   = in_q;
                4'd3: rdata_next[NumPads-1:0]   = pullup_q;
                4'd4: rdata_next[NumPads-1:0]   = pulldown_q;
                4'd5: rdata_next[4*NumPads-1:0] = strength_q;
                4'd6: rdata_next[NumPads-1:0]   = rise_en_q;
                4'd7: rdata_next[NumPads-1:0]   = fall_en_q;
                4'd8: rdata_next[NumPads-1:0]   = status_q;
                4'd9: rdata_next[CntWidth-1:0]  = debounce_q;
                default: rdata_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_q      <= '0;
            oe_q       <= '0;
            oe_n_q     <= '1;
            in_q       <= '0;
            pullup_q   <= '0;
            pulldown_q <= '0;
            strength_q <= {NumPads{DefStrength}};
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            status_q   <= '0;
            debounce_q <= '0;
            sync_p0    <= '0;
            sync_p1    <= '0;
            irq_q      <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            for (int k = 0; k < NumPads; k++) cnt_q[k] <= '0;
        end else begin
            if (wr) begin
                case (reg_addr_i)
                    4'd0: out_q      <= reg_wdata_i[NumPads-1:0];
                    4'd3: pullup_q   <= reg_wdata_i[NumPads-1:0];
                    4'd4: pulldown_q <= reg_wdata_i[NumPads-1:0];
                    4'd5: strength_q <= reg_wdata_i[4*NumPads-1:0];
                    4'd6: rise_en_q  <= reg_wdata_i[NumPads-1:0];
                    4'd7: fall_en_q  <= reg_wdata_i[NumPads-1:0];
                    4'd9: debounce_q <= reg_wdata_i[CntWidth-1:0];
                    default: ;
                endcase
            end
            oe_q    <= oe_next;
            // Drive only once OE was already set before this edge: one-cycle turnaround on enable.
            oe_n_q  <= ~(oe_q & oe_next);
            sync_p0 <= pad_data_i;
            sync_p1 <= sync_p0;
            in_q    <= in_next;
            for (int k = 0; k < NumPads; k++) cnt_q[k] <= cnt_next[k];
            status_q <= status_next;
            irq_q    <= |status_next;
            ready_q  <= reg_req_i;
            err_q    <= reg_req_i && (reg_addr_i >= 4'd10);
            rdata_q  <= rdata_next;
        end
    end

    assign reg_rdata_o       = rdata_q;
    assign reg_ready_o       = ready_q;
    assign reg_err_o         = err_q;
    assign pad_data_o        = out_q;
    assign pad_oe_no         = oe_n_q;
    assign pad_strength_o    = strength_q;
    assign pad_pullup_en_o   = pullup_q & ~pulldown_q;
    assign pad_pulldown_en_o = pulldown_q;
    assign irq_o             = irq_q;
    assign in_o              = in_q;

endmodule

// File: tb/tb_tc_io_pad_ctrl.sv
// Directed bench for tc_io_pad_ctrl: register access, OE turnaround, pulls,
// debounce latency and glitch rejection, W1C race and address errors.
module tb_tc_io_pad_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we;
    logic [3:0]  addr;
    logic [31:0] wdata, rdata;
    logic        ready, err;
    logic [7:0]  pad_out, oe_n, pu, pd, pad_in, in_v;
    logic [31:0] strength;
    logic        irq;
    logic [31:0] d;
    logic        e;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    tc_io_pad_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n),
        .reg_req_i(req), .reg_we_i(we), .reg_addr_i(addr), .reg_wdata_i(wdata),
        .reg_rdata_o(rdata), .reg_ready_o(ready), .reg_err_o(err),
        .pad_data_o(pad_out), .pad_oe_no(oe_n), .pad_strength_o(strength),
        .pad_pullup_en_o(pu), .pad_pulldown_en_o(pd), .pad_data_i(pad_in),
        .irq_o(irq), .in_o(in_v)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] v, output logic er);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = a; wdata = v;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        check("wr_ready", 32'(ready), 32'd1);
        er = err;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] v, output logic er);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        req = 1'b0;
        check("rd_ready", 32'(ready), 32'd1);
        v  = rdata;
        er = err;
        @(negedge clk);
        check("rd_ready_drop", 32'(ready), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; pad_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_oe_n", 32'(oe_n), 32'h0000_00FF);
        check("rst_strength", strength, 32'h4444_4444);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_pad_out", 32'(pad_out), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        rst_n = 1'b1;

        bus_read(4'd5, d, e);
        check("rd_strength", d, 32'h4444_4444);
        check("rd_strength_err", 32'(e), 32'd0);

        // Output enable turnaround
        bus_write(4'd0, 32'h01, e);
        check("pad_out", 32'(pad_out), 32'h01);
        bus_write(4'd1, 32'h01, e);
        check("oe_turn_wait", 32'(oe_n), 32'hFF);
        @(negedge clk);
        check("oe_turn_on", 32'(oe_n), 32'hFE);
        bus_write(4'd1, 32'h00, e);
        check("oe_off", 32'(oe_n), 32'hFF);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 4'd1; wdata = 32'h01;
        @(negedge clk);
        wdata = 32'h00;
        check("oe_reclr_a", 32'(oe_n), 32'hFF);
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        check("oe_reclr_b", 32'(oe_n), 32'hFF);
        @(negedge clk);
        check("oe_reclr_c", 32'(oe_n), 32'hFF);
        bus_read(4'd0, d, e);
        check("rd_out", d, 32'h01);

        // Pulls and strength
        bus_write(4'd3, 32'h03, e);
        bus_write(4'd4, 32'h02, e);
        check("pullup", 32'(pu), 32'h01);
        check("pulldown", 32'(pd), 32'h02);
        bus_write(4'd5, 32'h1234_5678, e);
        check("strength", strength, 32'h1234_5678);
        bus_read(4'd5, d, e);
        check("rd_strength2", d, 32'h1234_5678);

        // Debounce latency and rising-edge interrupt
        bus_write(4'd9, 32'd4, e);
        bus_write(4'd6, 32'h01, e);
        bus_read(4'd9, d, e);
        check("rd_debounce", d, 32'd4);
        @(negedge clk);
        pad_in = 8'h01;
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk);
            #1;
            check("deb_in", 32'(in_v[0]), (i == 7) ? 32'd1 : 32'd0);
            check("deb_irq", 32'(irq), (i == 7) ? 32'd1 : 32'd0);
        end
        bus_read(4'd2, d, e);
        check("rd_in", d, 32'h01);
        bus_read(4'd8, d, e);
        check("rd_status", d, 32'h01);
        bus_write(4'd8, 32'h01, e);
        check("w1c_irq", 32'(irq), 32'd0);

        // Short glitch must be filtered
        bus_write(4'd7, 32'h01, e);
        @(negedge clk);
        pad_in = 8'h00;
        repeat (3) @(negedge clk);
        pad_in = 8'h01;
        repeat (10) @(negedge clk);
        check("glitch_in", 32'(in_v), 32'h01);
        check("glitch_irq", 32'(irq), 32'd0);

        // W1C racing a falling-edge set: set wins
        @(negedge clk);
        pad_in = 8'h00;
        repeat (6) @(negedge clk);
        check("race_pre_in", 32'(in_v), 32'h01);
        req = 1'b1; we = 1'b1; addr = 4'd8; wdata = 32'h01;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        check("race_in", 32'(in_v), 32'h00);
        check("race_irq", 32'(irq), 32'd1);
        bus_read(4'd8, d, e);
        check("race_status", d, 32'h01);
        bus_write(4'd8, 32'h01, e);
        check("race_clr_irq", 32'(irq), 32'd0);

        // Address errors and read-only IN
        bus_read(4'd12, d, e);
        check("bad_rd_data", d, 32'd0);
        check("bad_rd_err", 32'(e), 32'd1);
        bus_write(4'd2, 32'hFF, e);
        check("in_wr_err", 32'(e), 32'd0);
        check("in_wr_val", 32'(in_v), 32'h00);
        bus_write(4'd15, 32'hFF, e);
        check("bad_wr_err", 32'(e), 32'd1);
        bus_read(4'd2, d, e);
        check("rd_in_after", d, 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
